phase1_framer: RTL and testbench

Downstream neighbour of the phase-1 CORDIC transmit stage. Consumes its n-bit output samples and their valid strobe, and buffers them in a small FIFO. Emits them on a 1-bit serial channel as frames: sync byte, FRAME_LEN samples, then an n-bit checksum. The channel applies bit-level backpressure through serial_ready.

---
 rtl/phase1_framer.sv | 213 +++++++++++++++++++++
 tb/tb_phase1_framer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase1_framer.sv
// Serial framer: FIFO-buffers CORDIC samples and sends sync, data, checksum.
// Optional per-sample even parity bit when PHASE1_FRAMER_PARITY_EN is defined.
module phase1_framer #(
    parameter int          n         = 16,
    parameter int          DEPTH     = 8,
    parameter int          FRAME_LEN = 4,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         enable,
    input  logic         input_valid,
    input  logic [n-1:0] input_num,
    input  logic         serial_ready,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         frame_start,
    output logic         overflow,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(n);
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam logic [n-1:0] SYNC_SH = {SYNC, {(n-8){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_CHECK
    } state_t;

    state_t         state_q;
    logic [n-1:0]   sh_q;
    logic [BW-1:0]  cnt_q;
    logic [IW-1:0]  idx_q;
    logic [n-1:0]   chk_q;
    logic           valid_q;
    logic           fs_q;
    logic           busy_q;
    logic           ovf_q;

    logic [n-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CW-1:0]  count_q;

    logic           xfer;
    logic           full;
    logic           have_frame;
    logic           last_smp;
    logic           smp_done;
    logic           pop;
    logic           push;
    logic [n-1:0]   head;

`ifdef PHASE1_FRAMER_PARITY_EN
    logic           par_q;
    logic           par_ph_q;
    assign smp_done = par_ph_q;
`else
    assign smp_done = 1'b1;
`endif

    assign xfer       = valid_q & serial_ready & enable;
    assign full       = (count_q == CW'(DEPTH));
    assign have_frame = (count_q >= CW'(FRAME_LEN));
    assign last_smp   = (idx_q == IW'(FRAME_LEN - 1));
    assign head       = mem[rd_q];

    // Only the sync->data hand-off and inter-sample boundaries consume FIFO data.
    assign pop  = xfer & (cnt_q == '0)
                & ((state_q == S_SYNC)
                 | ((state_q == S_DATA) & smp_done & ~last_smp));
    assign push = input_valid & enable & (~full | pop);

    assign serial_out   = sh_q[n-1];
    assign serial_valid = valid_q;
    assign frame_start  = fs_q;
    assign overflow     = ovf_q;
    assign busy         = busy_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_q] <= input_num;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push & ~pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop & ~push) begin
                count_q <= count_q - CW'(1);
            end
            if (input_valid & enable & full & ~pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            chk_q    <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PHASE1_FRAMER_PARITY_EN
            par_q    <= 1'b0;
            par_ph_q <= 1'b0;
`endif
        end else if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (have_frame) begin
                        state_q <= S_SYNC;
                        sh_q    <= SYNC_SH;
                        cnt_q   <= BW'(7);
                        valid_q <= 1'b1;
                        fs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_SYNC: begin
                    if (xfer) begin
                        fs_q <= 1'b0;
                        if (cnt_q != '0) begin
                            sh_q  <= {sh_q[n-2:0], 1'b0};
                            cnt_q <= cnt_q - BW'(1);
                        end else begin
                            sh_q    <= head;
                            cnt_q   <= BW'(n - 1);
                            chk_q   <= head;
                            idx_q   <= '0;
                            state_q <= S_DATA;
`ifdef PHASE1_FRAMER_PARITY_EN
                            par_q    <= ^head;
                            par_ph_q <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        if (cnt_q != '0) begin
                            sh_q  <= {sh_q[n-2:0], 1'b0};
                            cnt_q <= cnt_q - BW'(1);
`ifdef PHASE1_FRAMER_PARITY_EN
                        end else if (!par_ph_q) begin
                            sh_q     <= {par_q, {(n-1){1'b0}}};
                            par_ph_q <= 1'b1;
`endif
                        end else if (!last_smp) begin
                            sh_q  <= head;
                            cnt_q <= BW'(n - 1);
                            chk_q <= chk_q + head;
                            idx_q <= idx_q + IW'(1);
`ifdef PHASE1_FRAMER_PARITY_EN
                            par_q    <= ^head;
                            par_ph_q <= 1'b0;
`endif
                        end else begin
                            sh_q    <= chk_q;
                            cnt_q   <= BW'(n - 1);
                            state_q <= S_CHECK;
`ifdef PHASE1_FRAMER_PARITY_EN
                            par_ph_q <= 1'b0;
`endif
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (cnt_q != '0) begin
                            sh_q  <= {sh_q[n-2:0], 1'b0};
                            cnt_q <= cnt_q - BW'(1);
                        end else if (have_frame) begin
                            state_q <= S_SYNC;
                            sh_q    <= SYNC_SH;
                            cnt_q   <= BW'(7);
                            fs_q    <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase1_framer.sv
// Scoreboard bench for phase1_framer: expected bit stream queued per frame,
// a negedge monitor pops and compares on every accepted serial bit.
module tb_phase1_framer;

    localparam int N = 16;
`ifdef PHASE1_FRAMER_PARITY_EN
    localparam int FLEN = 92;
`else
    localparam int FLEN = 88;
`endif

    logic         clock        = 1'b0;
    logic         resetn       = 1'b1;
    logic         enable       = 1'b1;
    logic         input_valid  = 1'b0;
    logic [N-1:0] input_num    = '0;
    logic         serial_ready = 1'b1;
    logic         serial_out;
    logic         serial_valid;
    logic         frame_start;
    logic         overflow;
    logic         busy;

    int   errors = 0;
    int   checks = 0;
    int   vcnt   = 0;
    int   fscnt  = 0;
    int   xcnt   = 0;
    int   rmode  = 0;
    logic first_rdy = 1'b0;
    logic [1:0] sbq [$];

    phase1_framer dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .input_valid (input_valid),
        .input_num   (input_num),
        .serial_ready(serial_ready),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .frame_start (frame_start),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d,
                             input logic [15:0] ck);
        logic [7:0]  sy = 8'hA5;
        logic [15:0] s [4];
        s[0] = a;
        s[1] = b;
        s[2] = c;
        s[3] = d;
        for (int i = 7; i >= 0; i--) sbq.push_back({i == 7, sy[i]});
        for (int k = 0; k < 4; k++) begin
            for (int i = 15; i >= 0; i--) sbq.push_back({1'b0, s[k][i]});
`ifdef PHASE1_FRAMER_PARITY_EN
            sbq.push_back({1'b0, ^s[k]});
`endif
        end
        for (int i = 15; i >= 0; i--) sbq.push_back({1'b0, ck[i]});
    endtask

    task automatic push(input logic [15:0] v);
        input_valid = 1'b1;
        input_num   = v;
        @(posedge clock); #1;
        input_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(posedge clock); #1;
        while ((busy || serial_valid) && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        chk("idle_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic set_rmode(input int m);
        #1;
        rmode = m;
        @(posedge clock); #2;
    endtask

    task automatic clr_cnt();
        vcnt  = 0;
        fscnt = 0;
        xcnt  = 0;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_serial_out"},   32'(serial_out),   32'd0);
        chk({tag, "_serial_valid"}, 32'(serial_valid), 32'd0);
        chk({tag, "_frame_start"},  32'(frame_start),  32'd0);
        chk({tag, "_overflow"},     32'(overflow),     32'd0);
        chk({tag, "_busy"},         32'(busy),         32'd0);
    endtask

    initial forever begin
        @(posedge clock); #1;
        case (rmode)
            0:       serial_ready = 1'b1;
            1:       serial_ready = ~serial_ready;
            default: serial_ready = 1'b0;
        endcase
    end

    initial forever begin
        logic [1:0] e;
        @(negedge clock);
        if (serial_valid) begin
            if (vcnt == 0) first_rdy = serial_ready;
            vcnt++;
        end
        if (frame_start) fscnt++;
        if (serial_valid && serial_ready && enable && !resetn) begin
            xcnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underrun: got bit %0b expected no transfer",
                         serial_out);
            end else begin
                e = sbq.pop_front();
                chk("serial_bit", 32'(serial_out), 32'(e[0]));
                chk("frame_start_bit", 32'(frame_start), 32'(e[1]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic so;
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetn = 1'b0;
        chk_zero_outs("reset");

        // basic frame, ready held high
        clr_cnt();
        exp_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A);
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        push(16'h0004);
        chk("lat_valid_early", 32'(serial_valid), 32'd0);
        chk("lat_busy_early",  32'(busy),         32'd0);
        @(posedge clock); #1;
        chk("lat_busy",  32'(busy),         32'd1);
        chk("lat_valid", 32'(serial_valid), 32'd1);
        chk("lat_fs",    32'(frame_start),  32'd1);
        wait_idle(FLEN * 2 + 20);
        chk("t1_valid_cycles", 32'(vcnt),  32'(FLEN));
        chk("t1_fs_cycles",    32'(fscnt), 32'd1);
        chk("t1_xfers",        32'(xcnt),  32'(FLEN));
        chk("t1_busy_end",     32'(busy),  32'd0);
        chk("t1_drain",        32'(sbq.size()), 32'd0);

        // toggled ready
        set_rmode(1);
        clr_cnt();
        exp_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A);
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        push(16'h0004);
        wait_idle(FLEN * 4 + 20);
        chk("t2_valid_cycles", 32'(vcnt), 32'(2 * FLEN - int'(first_rdy)));
        chk("t2_xfers",        32'(xcnt), 32'(FLEN));
        chk("t2_drain",        32'(sbq.size()), 32'd0);

        // checksum wrap
        set_rmode(0);
        clr_cnt();
        exp_frame(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0001);
        push(16'hFFFF);
        push(16'h0002);
        push(16'h0000);
        push(16'h0000);
        wait_idle(FLEN * 2 + 20);
        chk("t3_xfers", 32'(xcnt), 32'(FLEN));
        chk("t3_drain", 32'(sbq.size()), 32'd0);

        // overflow and back-to-back frames
        set_rmode(2);
        @(posedge clock); #1;
        exp_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA);
        exp_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'hBBBA);
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        push(16'h5555);
        push(16'h6666);
        push(16'h7777);
        push(16'h8888);
        chk("ovf_before", 32'(overflow), 32'd0);
        push(16'h9999);
        chk("ovf_after", 32'(overflow), 32'd1);
        set_rmode(0);
        clr_cnt();
        wait_idle(FLEN * 4 + 20);
        chk("t4_valid_cycles", 32'(vcnt), 32'(2 * FLEN));
        chk("t4_xfers",        32'(xcnt), 32'(2 * FLEN));
        chk("t4_ovf_sticky",   32'(overflow), 32'd1);
        chk("t4_drain",        32'(sbq.size()), 32'd0);

        // enable stall mid-DATA with input_valid asserted
        clr_cnt();
        exp_frame(16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'hF00F);
        push(16'h8001);
        push(16'h4002);
        push(16'h2004);
        push(16'h1008);
        repeat (14) begin
            @(posedge clock); #1;
        end
        enable      = 1'b0;
        input_valid = 1'b1;
        input_num   = 16'h7777;
        so          = serial_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("stall_out",   32'(serial_out),   32'(so));
            chk("stall_valid", 32'(serial_valid), 32'd1);
            chk("stall_busy",  32'(busy),         32'd1);
        end
        enable      = 1'b1;
        input_valid = 1'b0;
        wait_idle(FLEN * 2 + 20);
        chk("t5_valid_cycles", 32'(vcnt), 32'(FLEN + 5));
        chk("t5_xfers",        32'(xcnt), 32'(FLEN));
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("t5_no_push", 32'(busy), 32'd0);
        chk("t5_drain",   32'(sbq.size()), 32'd0);

        // reset mid-DATA, then a fresh frame
        exp_frame(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h0648);
        push(16'hDEAD);
        push(16'hBEEF);
        push(16'h1234);
        push(16'h5678);
        repeat (30) begin
            @(posedge clock); #1;
        end
        resetn = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b0;
        chk_zero_outs("midreset");
        sbq.delete();
        clr_cnt();
        @(posedge clock); #1;
        chk("midreset_idle", 32'(busy), 32'd0);
        exp_frame(16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h00F0);
        push(16'h0010);
        push(16'h0020);
        push(16'h0040);
        push(16'h0080);
        wait_idle(FLEN * 2 + 20);
        chk("t6_xfers", 32'(xcnt), 32'(FLEN));
        chk("t6_drain", 32'(sbq.size()), 32'd0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("t6_busy_end", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
